multicycle_cpu_core: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 8-bit accumulator-style CPU. It has a generic data width, address width and register count, and an FSM sequencer: fetch, execute, memory, I/O wait.
Instruction and data memories are external. The I/O ports gain valid/ready handshakes with stall-on-backpressure, which the previous single-cycle core lacked.
It sits as the processor core under the project top level.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/cpu_alu.sv | 30 +++
 rtl/multicycle_cpu_core.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_cpu_core.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU core: opcodes, sequencer states
// and instruction field offsets (measured from the top of the ea field).
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_NAND  = 4'h3;
  localparam logic [3:0] OP_SHL   = 4'h4;
  localparam logic [3:0] OP_SHR   = 4'h5;
  localparam logic [3:0] OP_MOV   = 4'h6;
  localparam logic [3:0] OP_LDI   = 4'h7;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_IN    = 4'hA;
  localparam logic [3:0] OP_OUT   = 4'hB;
  localparam logic [3:0] OP_BR    = 4'hC;
  localparam logic [3:0] OP_JMP   = 4'hD;
  localparam logic [3:0] OP_CALL  = 4'hE;
  localparam logic [3:0] OP_SYS   = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_IN_WAIT,
    S_OUT_WAIT,
    S_HALT
  } state_e;

  // Word layout: {op[3:0], ra[3:0], rb[3:0], brx, 3'b0, ea[ADDR_W-1:0]};
  // each offset is added to ADDR_W to get the absolute bit position.
  localparam int OP_LSB  = 12;
  localparam int RA_LSB  = 8;
  localparam int RB_LSB  = 4;
  localparam int BRX_BIT = 3;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the multicycle core; flags are derived from the result.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              n_o,
  output logic              z_o
);

  always_comb begin
    result_o = b_i;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_NAND: result_o = ~(a_i & b_i);
      OP_SHL:  result_o = b_i << 1;
      OP_SHR:  result_o = b_i >> 1;
      default: result_o = b_i;
    endcase
  end

  assign n_o = result_o[DATA_W-1];
  assign z_o = (result_o == '0);

endmodule

// File: rtl/multicycle_cpu_core.sv
// Multicycle accumulator-style CPU: FETCH/EXEC/MEM sequencer with valid/ready I/O.
// Define CPU_CALL_STACK_EN to replace the single link register with a return stack.
module multicycle_cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int REG_CNT     = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [15+ADDR_W:0]  imem_data,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic                dmem_we,
  input  logic [DATA_W-1:0]   dmem_rdata,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                halted
);

  localparam int RI_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc;
  logic [15+ADDR_W:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   regs_q [REG_CNT];
  logic [DATA_W-1:0]   regs_d [REG_CNT];
  logic                n_q, n_d, z_q, z_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic [3:0]          op;
  logic [RI_W-1:0]     ra_idx, rb_idx;
  logic                brx;
  logic [ADDR_W-1:0]   ea;
  logic [DATA_W-1:0]   ra_val, rb_val, ldi_val, alu_res;
  logic                alu_n, alu_z;
  logic                unused_ir;

  assign op      = ir_q[ADDR_W+OP_LSB +: 4];
  assign ra_idx  = ir_q[ADDR_W+RA_LSB +: RI_W];
  assign rb_idx  = ir_q[ADDR_W+RB_LSB +: RI_W];
  assign brx     = ir_q[ADDR_W+BRX_BIT];
  assign ea      = ir_q[ADDR_W-1:0];
  assign ra_val  = regs_q[ra_idx];
  assign rb_val  = regs_q[rb_idx];
  assign ldi_val = DATA_W'(ea);
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign unused_ir = ^ir_q;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i     (op),
    .a_i      (ra_val),
    .b_i      (rb_val),
    .result_o (alu_res),
    .n_o      (alu_n),
    .z_o      (alu_z)
  );

`ifdef CPU_CALL_STACK_EN
  localparam int SP_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d, sp_inc, sp_dec;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // sp_q points at the next free slot; a push onto a full stack overwrites the oldest entry
  assign sp_inc = (sp_q == SP_W'(STACK_DEPTH-1)) ? '0 : sp_q + SP_W'(1);
  assign sp_dec = (sp_q == '0) ? SP_W'(STACK_DEPTH-1) : sp_q - SP_W'(1);
`else
  localparam int unused_stack_depth = STACK_DEPTH;
  logic [ADDR_W-1:0] lr_q, lr_d;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    regs_d     = regs_q;
    n_d        = n_q;
    z_d        = z_q;
    out_data_d = out_data_q;
`ifdef CPU_CALL_STACK_EN
    stack_d    = stack_q;
    sp_d       = sp_q;
    cnt_d      = cnt_q;
`else
    lr_d       = lr_q;
`endif
    case (state_q)
      S_FETCH: begin
        ir_d    = imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR: begin
            regs_d[ra_idx] = alu_res;
            n_d = alu_n;
            z_d = alu_z;
          end
          OP_MOV:  regs_d[ra_idx] = alu_res;
          OP_LDI:  regs_d[ra_idx] = ldi_val;
          OP_LOAD: state_d = S_MEM;
          OP_IN:   state_d = S_IN_WAIT;
          OP_OUT: begin
            out_data_d = ra_val;
            state_d    = S_OUT_WAIT;
          end
          OP_BR:   if (brx ? n_q : z_q) pc_d = ea;
          OP_JMP:  pc_d = ea;
          OP_CALL: begin
            pc_d = ea;
`ifdef CPU_CALL_STACK_EN
            stack_d[sp_q] = pc_inc;
            sp_d = sp_inc;
            if (cnt_q != CNT_W'(STACK_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
`else
            lr_d = pc_inc;
`endif
          end
          OP_SYS: begin
            if (brx) begin
              state_d = S_HALT;
            end else begin
`ifdef CPU_CALL_STACK_EN
              if (cnt_q == '0) begin
                pc_d    = pc_q;
                state_d = S_HALT;
              end else begin
                pc_d  = stack_q[sp_dec];
                sp_d  = sp_dec;
                cnt_d = cnt_q - CNT_W'(1);
              end
`else
              pc_d = lr_q;
`endif
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        regs_d[ra_idx] = dmem_rdata;
        state_d        = S_FETCH;
      end
      S_IN_WAIT: begin
        if (in_valid) begin
          regs_d[ra_idx] = in_data;
          state_d        = S_FETCH;
        end
      end
      S_OUT_WAIT: if (out_ready) state_d = S_FETCH;
      S_HALT:     ;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
      out_data_q <= '0;
      for (int i = 0; i < REG_CNT; i++) regs_q[i] <= '0;
`ifdef CPU_CALL_STACK_EN
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
`else
      lr_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      n_q        <= n_d;
      z_q        <= z_d;
      out_data_q <= out_data_d;
      regs_q     <= regs_d;
`ifdef CPU_CALL_STACK_EN
      stack_q <= stack_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
`else
      lr_q    <= lr_d;
`endif
    end
  end

  // Handshake outputs decode straight from state so reset drops them immediately.
  // in/out follow valid/ready: a transfer happens on a rising edge where both are high.
  assign imem_addr  = pc_q;
  assign dmem_addr  = ea;
  assign dmem_wdata = ra_val;
  assign dmem_we    = (state_q == S_EXEC) && (op == OP_STORE);
  assign in_ready   = (state_q == S_IN_WAIT);
  assign out_valid  = (state_q == S_OUT_WAIT);
  assign out_data   = out_data_q;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed-program bench for multicycle_cpu_core; output transfers are scored
// against an expected queue, timing and stall behaviour checked at negedges.
module tb_multicycle_cpu_core;
  import cpu_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int IW = 16 + AW;

  localparam int W_OUT_VALID = 0;
  localparam int W_IN_READY  = 1;
  localparam int W_HALTED    = 2;
  localparam int W_DMEM_WE   = 3;
  localparam int W_PC        = 4;
  localparam int W_SB_EMPTY  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_we;
  logic [DW-1:0] dmem_rdata;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          halted;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  logic [IW-1:0] imem [256];
  logic [DW-1:0] dmem [256];

  multicycle_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .REG_CNT(4), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .halted     (halted)
  );

  // clock/reset
  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];

  always @(posedge clk) begin
    dmem_rdata <= dmem[dmem_addr];
    if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every accepted output word must be the next expected one
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      // a transfer with nothing expected has no legal value
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : ~out_data;
      check("out_xfer", out_data, mon_exp);
    end
  end

  function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic brx,
                                        input logic [7:0] ea);
    return {op, ra, rb, brx, 3'b000, ea};
  endfunction

  function automatic bit cond_met(input int sel, input logic [7:0] val);
    case (sel)
      W_OUT_VALID: return out_valid;
      W_IN_READY:  return in_ready;
      W_HALTED:    return halted;
      W_DMEM_WE:   return dmem_we;
      W_PC:        return imem_addr == val;
      default:     return exp_q.size() == 0;
    endcase
  endfunction

  // driver tasks
  task automatic wait_for(input string tag, input int sel, input logic [7:0] val,
                          input int max, output int n);
    bit hit = 1'b0;
    n = 0;
    while (!hit && n < max) begin
      @(negedge clk);
      n++;
      hit = cond_met(sel, val);
    end
    check({tag, "_seen"}, 32'(hit), 32'd1);
  endtask

  task automatic enter_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      imem[i] = ins(OP_SYS, 4'd0, 4'd0, 1'b1, 8'h00);
      dmem[i] = '0;
    end
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_pc", imem_addr, 8'h00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_dmem_we", dmem_we, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_out_data", out_data, 8'h00);

    // arithmetic, flags and branches
    enter_reset();
    imem[8'h00] = ins(OP_LDI, 4'd0, 4'd0, 1'b0, 8'h05);
    imem[8'h01] = ins(OP_LDI, 4'd1, 4'd0, 1'b0, 8'h03);
    imem[8'h02] = ins(OP_SUB, 4'd0, 4'd1, 1'b0, 8'h00);
    imem[8'h03] = ins(OP_OUT, 4'd0, 4'd0, 1'b0, 8'h00);
    imem[8'h04] = ins(OP_BR,  4'd0, 4'd0, 1'b0, 8'h20);
    imem[8'h05] = ins(OP_BR,  4'd0, 4'd0, 1'b1, 8'h30);
    imem[8'h06] = ins(OP_SUB, 4'd0, 4'd0, 1'b0, 8'h00);
    imem[8'h07] = ins(OP_OUT, 4'd0, 4'd0, 1'b0, 8'h00);
    imem[8'h08] = ins(OP_BR,  4'd0, 4'd0, 1'b0, 8'h20);
    imem[8'h20] = ins(OP_LDI, 4'd1, 4'd0, 1'b0, 8'h01);
    imem[8'h21] = ins(OP_SUB, 4'd2, 4'd1, 1'b0, 8'h00);
    imem[8'h22] = ins(OP_BR,  4'd0, 4'd0, 1'b1, 8'h30);
    imem[8'h30] = ins(OP_OUT, 4'd2, 4'd0, 1'b0, 8'h00);
    exp_q = '{8'h02, 8'h00, 8'hFF};
    rst = 1'b0;
    wait_for("a_out", W_OUT_VALID, 8'h00, 40, n);
    check("a_out_latency", n, 8);
    check("a_out_data", out_data, 8'h02);
    @(negedge clk);
    check("a_out_pulse", out_valid, 1'b0);
    wait_for("a_halt", W_HALTED, 8'h00, 200, n);
    check("a_halt_pc", imem_addr, 8'h32);
    repeat (3) @(negedge clk);
    check("a_pc_frozen", imem_addr, 8'h32);
    check("a_halted_held", halted, 1'b1);
    check("a_sb_drained", 32'(exp_q.size()), 32'd0);

    // memory, input stall, call/return, output backpressure, remaining ALU ops
    enter_reset();
    imem[8'h00] = ins(OP_LDI,   4'd0, 4'd0, 1'b0, 8'h7F);
    imem[8'h01] = ins(OP_STORE, 4'd0, 4'd0, 1'b0, 8'h10);
    imem[8'h02] = ins(OP_LOAD,  4'd2, 4'd0, 1'b0, 8'h10);
    imem[8'h03] = ins(OP_OUT,   4'd2, 4'd0, 1'b0, 8'h00);
    imem[8'h04] = ins(OP_IN,    4'd3, 4'd0, 1'b0, 8'h00);
    imem[8'h05] = ins(OP_CALL,  4'd0, 4'd0, 1'b0, 8'h40);
    imem[8'h06] = ins(OP_OUT,   4'd3, 4'd0, 1'b0, 8'h00);
    imem[8'h07] = ins(OP_ADD,   4'd3, 4'd0, 1'b0, 8'h00);
    imem[8'h08] = ins(OP_OUT,   4'd3, 4'd0, 1'b0, 8'h00);
    imem[8'h09] = ins(OP_NAND,  4'd3, 4'd0, 1'b0, 8'h00);
    imem[8'h0A] = ins(OP_OUT,   4'd3, 4'd0, 1'b0, 8'h00);
    imem[8'h0B] = ins(OP_SHL,   4'd1, 4'd3, 1'b0, 8'h00);
    imem[8'h0C] = ins(OP_SHR,   4'd2, 4'd3, 1'b0, 8'h00);
    imem[8'h0D] = ins(OP_OUT,   4'd1, 4'd0, 1'b0, 8'h00);
    imem[8'h0E] = ins(OP_OUT,   4'd2, 4'd0, 1'b0, 8'h00);
    imem[8'h40] = ins(OP_SHR,   4'd1, 4'd3, 1'b0, 8'h00);
    imem[8'h41] = ins(OP_OUT,   4'd1, 4'd0, 1'b0, 8'h00);
    imem[8'h42] = ins(OP_SYS,   4'd0, 4'd0, 1'b0, 8'h00);
    exp_q = '{8'h7F, 8'h52, 8'hA5, 8'h24, 8'hDB, 8'hB6, 8'h6D};
    rst = 1'b0;
    wait_for("b_store", W_DMEM_WE, 8'h00, 20, n);
    check("b_store_addr", dmem_addr, 8'h10);
    check("b_store_data", dmem_wdata, 8'h7F);
    @(negedge clk);
    check("b_we_pulse", dmem_we, 1'b0);
    wait_for("b_load_out", W_OUT_VALID, 8'h00, 20, n);
    check("b_load_latency", n, 5);
    wait_for("b_in", W_IN_READY, 8'h00, 20, n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b_in_ready_hold", in_ready, 1'b1);
      check("b_in_pc_hold", imem_addr, 8'h05);
    end
    in_data  = 8'hA5;
    in_valid = 1'b1;
    @(negedge clk);
    check("b_in_ready_drop", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_for("b_sub_out", W_OUT_VALID, 8'h00, 20, n);
    check("b_sub_pc", imem_addr, 8'h42);
    @(negedge clk);
    out_ready = 1'b0;
    wait_for("b_bp", W_OUT_VALID, 8'h00, 20, n);
    for (int i = 0; i < 4; i++) begin
      check("b_bp_valid", out_valid, 1'b1);
      check("b_bp_data", out_data, 8'hA5);
      check("b_ret_pc", imem_addr, 8'h07);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("b_bp_release", out_valid, 1'b0);
    wait_for("b_halt", W_HALTED, 8'h00, 300, n);
    check("b_halt_pc", imem_addr, 8'h10);
    check("b_sb_drained", 32'(exp_q.size()), 32'd0);

`ifdef CPU_CALL_STACK_EN
    // five nested calls into a four-deep stack, then unwind until empty
    enter_reset();
    for (int k = 0; k < 5; k++) begin
      imem[k*16]     = ins(OP_CALL, 4'd0, 4'd0, 1'b0, 8'((k+1)*16));
      imem[k*16 + 1] = ins(OP_LDI,  4'd0, 4'd0, 1'b0, 8'(k));
      imem[k*16 + 2] = ins(OP_OUT,  4'd0, 4'd0, 1'b0, 8'h00);
      imem[k*16 + 3] = ins(OP_SYS,  4'd0, 4'd0, 1'b0, 8'h00);
    end
    imem[8'h50] = ins(OP_SYS, 4'd0, 4'd0, 1'b0, 8'h00);
    exp_q = '{8'h04, 8'h03, 8'h02, 8'h01};
    rst = 1'b0;
    wait_for("d_halt", W_HALTED, 8'h00, 400, n);
    check("d_halt_pc", imem_addr, 8'h13);
    check("d_sb_drained", 32'(exp_q.size()), 32'd0);
`else
    // nested call overwrites the single link register
    enter_reset();
    imem[8'h00] = ins(OP_LDI,  4'd1, 4'd0, 1'b0, 8'h01);
    imem[8'h01] = ins(OP_CALL, 4'd0, 4'd0, 1'b0, 8'h10);
    imem[8'h10] = ins(OP_CALL, 4'd0, 4'd0, 1'b0, 8'h20);
    imem[8'h11] = ins(OP_ADD,  4'd0, 4'd1, 1'b0, 8'h00);
    imem[8'h12] = ins(OP_OUT,  4'd0, 4'd0, 1'b0, 8'h00);
    imem[8'h13] = ins(OP_SYS,  4'd0, 4'd0, 1'b0, 8'h00);
    imem[8'h20] = ins(OP_SYS,  4'd0, 4'd0, 1'b0, 8'h00);
    exp_q = '{8'h01, 8'h02, 8'h03};
    rst = 1'b0;
    wait_for("d_lr_loop", W_SB_EMPTY, 8'h00, 200, n);
    check("d_not_halted", halted, 1'b0);
`endif

    // pc wrap and reset during an output wait
    enter_reset();
    imem[8'h00] = ins(OP_OUT, 4'd0, 4'd0, 1'b0, 8'h00);
    imem[8'h01] = ins(OP_LDI, 4'd0, 4'd0, 1'b0, 8'h33);
    imem[8'h02] = ins(OP_JMP, 4'd0, 4'd0, 1'b0, 8'hFF);
    imem[8'hFF] = ins(OP_NOP, 4'd0, 4'd0, 1'b0, 8'h00);
    exp_q = '{8'h00, 8'h33};
    rst = 1'b0;
    wait_for("c_at_ff", W_PC, 8'hFF, 40, n);
    repeat (2) @(negedge clk);
    check("c_wrap_pc", imem_addr, 8'h00);
    wait_for("c_sb", W_SB_EMPTY, 8'h00, 40, n);
    out_ready = 1'b0;
    wait_for("c_out3", W_OUT_VALID, 8'h00, 40, n);
    check("c_out3_data", out_data, 8'h33);
    rst = 1'b1;
    #1;
    check("c_rst_out_valid", out_valid, 1'b0);
    check("c_rst_pc", imem_addr, 8'h00);
    check("c_rst_in_ready", in_ready, 1'b0);
    check("c_rst_halted", halted, 1'b0);
    check("c_rst_out_data", out_data, 8'h00);
    repeat (2) @(negedge clk);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
